ex_stage: RTL and testbench

- Execute stage; sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Computes the RV32I ALU result and the RV32M multiply result combinationally.
- Runs signed and unsigned divide/remainder on an iterative radix-2 divider, requesting a pipeline stall while it works.
- Forwards destination, write-enable and the store operand unchanged.

---
 rtl/riscv_defs.sv | 35 +++
 rtl/div_iter.sv | 81 ++++++++
 rtl/ex_stage.sv | 111 +++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared encodings for the execute stage: result-group selects, ALU opcodes
// and the divider FSM state.
package riscv_defs;
    localparam logic [2:0] SEL_NOP    = 3'd0;
    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MULDIV = 3'd4;
    localparam logic [2:0] SEL_PASS   = 3'd5;

    localparam logic [6:0] OP_OR     = 7'h01;
    localparam logic [6:0] OP_AND    = 7'h02;
    localparam logic [6:0] OP_XOR    = 7'h03;
    localparam logic [6:0] OP_SLL    = 7'h04;
    localparam logic [6:0] OP_SRL    = 7'h05;
    localparam logic [6:0] OP_SRA    = 7'h06;
    localparam logic [6:0] OP_ADD    = 7'h07;
    localparam logic [6:0] OP_SUB    = 7'h08;
    localparam logic [6:0] OP_SLT    = 7'h09;
    localparam logic [6:0] OP_SLTU   = 7'h0A;
    localparam logic [6:0] OP_MUL    = 7'h0B;
    localparam logic [6:0] OP_MULH   = 7'h0C;
    localparam logic [6:0] OP_MULHSU = 7'h0D;
    localparam logic [6:0] OP_MULHU  = 7'h0E;
    localparam logic [6:0] OP_DIV    = 7'h0F;
    localparam logic [6:0] OP_DIVU   = 7'h10;
    localparam logic [6:0] OP_REM    = 7'h11;
    localparam logic [6:0] OP_REMU   = 7'h12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider on operand magnitudes. Latches the
// result sign flags at start so the caller can sign-correct in DONE.
module div_iter
    import riscv_defs::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            q_neg,
    output logic            r_neg
);
    localparam int CW = $clog2(DIV_CYCLES);

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dq, rem, dvsr;
    logic [XLEN:0]   trial;
    logic            dvd_neg, dvs_neg;

    assign dvd_neg = signed_op & dividend[XLEN-1];
    assign dvs_neg = signed_op & divisor[XLEN-1];
    // Partial remainder shifted left by one bit, minus divisor; MSB is the borrow.
    assign trial   = {rem, dq[XLEN-1]} - {1'b0, dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dq    <= '0;
            rem   <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dq    <= dvd_neg ? -dividend : dividend;
                    dvsr  <= dvs_neg ? -divisor : divisor;
                    rem   <= '0;
                    q_neg <= dvd_neg ^ dvs_neg;
                    r_neg <= dvd_neg;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    if (trial[XLEN]) begin
                        rem <= {rem[XLEN-2:0], dq[XLEN-1]};
                        dq  <= {dq[XLEN-2:0], 1'b0};
                    end else begin
                        rem <= trial[XLEN-1:0];
                        dq  <= {dq[XLEN-2:0], 1'b1};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIV_CYCLES - 1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign quotient  = dq;
    assign remainder = rem;
endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: combinational ALU and multiplier, iterative divider
// with pipeline stall, and pass-through of writeback/store fields.
module ex_stage
    import riscv_defs::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      aluop_i,
    input  logic [2:0]      alusel_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [XLEN-1:0] reg_last_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic            flush_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic [6:0]      aluop_o,
    output logic            stall_req_o,
    output logic            div_busy_o
);
    logic                   is_div, signed_div, div_zero, div_ovf, div_start;
    logic                   div_busy, div_done, q_neg, r_neg;
    logic                   a_sext, b_sext;
    logic [XLEN-1:0]        quotient, remainder, q_fix, r_fix;
    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;

    // The 33x33 signed product, carried at 2*XLEN so both halves are usable.
    assign a_sext = (aluop_i != OP_MULHU);
    assign b_sext = (aluop_i == OP_MULH) || (aluop_i == OP_MUL);
    assign mul_a  = {{XLEN{a_sext & reg1_i[XLEN-1]}}, reg1_i};
    assign mul_b  = {{XLEN{b_sext & reg2_i[XLEN-1]}}, reg2_i};
    assign prod   = mul_a * mul_b;

    assign is_div     = (alusel_i == SEL_MULDIV) &&
                        (aluop_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    assign signed_div = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
    assign div_zero   = (reg2_i == '0);
    assign div_ovf    = signed_div && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (reg2_i == '1);
    assign div_start  = is_div & ~div_zero & ~div_ovf & ~div_busy & ~flush_i;

    div_iter #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .signed_op (signed_div),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .flush     (flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder),
        .q_neg     (q_neg),
        .r_neg     (r_neg)
    );

    assign q_fix = q_neg ? -quotient : quotient;
    assign r_fix = r_neg ? -remainder : remainder;

    always_comb begin
        wdata_o = '0;
        case (alusel_i)
            SEL_LOGIC: case (aluop_i)
                OP_OR:   wdata_o = reg1_i | reg2_i;
                OP_AND:  wdata_o = reg1_i & reg2_i;
                OP_XOR:  wdata_o = reg1_i ^ reg2_i;
                default: wdata_o = '0;
            endcase
            SEL_SHIFT: case (aluop_i)
                OP_SLL:  wdata_o = reg1_i << reg2_i[4:0];
                OP_SRL:  wdata_o = reg1_i >> reg2_i[4:0];
                OP_SRA:  wdata_o = $signed(reg1_i) >>> reg2_i[4:0];
                default: wdata_o = '0;
            endcase
            SEL_ARITH: case (aluop_i)
                OP_ADD:  wdata_o = reg1_i + reg2_i;
                OP_SUB:  wdata_o = reg1_i - reg2_i;
                OP_SLT:  wdata_o = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
                OP_SLTU: wdata_o = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
                default: wdata_o = '0;
            endcase
            SEL_MULDIV: case (aluop_i)
                OP_MUL:                      wdata_o = prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: wdata_o = prod[2*XLEN-1:XLEN];
                // Special cases resolve in IDLE; otherwise only DONE drives a result.
                OP_DIV, OP_DIVU: wdata_o = div_done ? q_fix :
                                           div_zero ? '1 :
                                           div_ovf  ? reg1_i : '0;
                OP_REM, OP_REMU: wdata_o = div_done ? r_fix :
                                           div_zero ? reg1_i : '0;
                default:                     wdata_o = '0;
            endcase
            SEL_PASS: wdata_o = reg2_i;
            default:  wdata_o = '0;
        endcase
    end

    assign stall_req_o = div_start | (div_busy & ~div_done);
    assign div_busy_o  = div_busy;
    assign wreg_o      = wreg_i & ~stall_req_o;
    assign wd_o        = wd_i;
    assign mem_data_o  = reg_last_i;
    assign aluop_o     = aluop_i;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;
    import riscv_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, reg_last_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, mem_data_o;
    logic [6:0]  aluop_o;
    logic        stall_req_o, div_busy_o;

    int tests = 0;
    int fails = 0;

    ex_stage #(.DIV_CYCLES(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .reg_last_i(reg_last_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .mem_data_o(mem_data_o), .aluop_o(aluop_o),
        .stall_req_o(stall_req_o), .div_busy_o(div_busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] s, input logic [6:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub, p;
        longint unsigned pu;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        model = '0;
        case (s)
            SEL_LOGIC: case (op)
                OP_OR: model = a | b;
                OP_AND: model = a & b;
                OP_XOR: model = a ^ b;
                default: model = '0;
            endcase
            SEL_SHIFT: case (op)
                OP_SLL: model = a << b[4:0];
                OP_SRL: model = a >> b[4:0];
                OP_SRA: model = ia >>> b[4:0];
                default: model = '0;
            endcase
            SEL_ARITH: case (op)
                OP_ADD: model = a + b;
                OP_SUB: model = a - b;
                OP_SLT: model = (ia < ib) ? 32'd1 : 32'd0;
                OP_SLTU: model = (a < b) ? 32'd1 : 32'd0;
                default: model = '0;
            endcase
            SEL_MULDIV: case (op)
                OP_MUL: begin p = sa * sb; model = p[31:0]; end
                OP_MULH: begin p = sa * sb; model = p[63:32]; end
                OP_MULHSU: begin p = sa * ub; model = p[63:32]; end
                OP_MULHU: begin pu = {32'b0, a} * {32'b0, b}; model = pu[63:32]; end
                OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                    if (b == 0)
                        model = (op == OP_DIV || op == OP_DIVU) ? 32'hFFFFFFFF : a;
                    else if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
                        model = (op == OP_DIV) ? 32'h80000000 : 32'h0;
                    else if (op == OP_DIV)  model = ia / ib;
                    else if (op == OP_DIVU) model = a / b;
                    else if (op == OP_REM)  model = ia % ib;
                    else                    model = a % b;
                end
                default: model = '0;
            endcase
            SEL_PASS: model = b;
            default: model = '0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] s, input logic [6:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_i = s;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    // Present a divide, count stall cycles, then check the DONE-cycle result.
    task automatic run_div(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit chk_idle);
        int n;
        bit leak;
        @(negedge clk);
        drive(SEL_MULDIV, op, a, b);
        wreg_i = 1'b1;
        #1;
        n = 0;
        leak = 1'b0;
        while (stall_req_o && n < 100) begin
            if (wreg_o !== 1'b0) leak = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        tests++;
        if (n !== 33) begin fails++; $display("FAIL div_stall_cycles op=%h got %0d exp 33", op, n); end
        tests++;
        if (leak) begin fails++; $display("FAIL div_wreg_mask op=%h got wreg_o=1 during stall exp 0", op); end
        tests++;
        if (wdata_o !== exp) begin fails++; $display("FAIL div_result op=%h a=%h b=%h got %h exp %h", op, a, b, wdata_o, exp); end
        tests++;
        if (wreg_o !== 1'b1) begin fails++; $display("FAIL div_done_wreg got %b exp 1", wreg_o); end
        if (chk_idle) begin
            @(negedge clk);
            drive(SEL_NOP, 7'h00, 32'h0, 32'h0);
            #1;
            tests++;
            if (div_busy_o !== 1'b0) begin fails++; $display("FAIL div_idle_after_done got busy=%b exp 0", div_busy_o); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(SEL_NOP, 7'h00, 32'h0, 32'h0);
        reg_last_i = '0; wd_i = '0; wreg_i = 1'b0; flush_i = 1'b0;
        #12;
        tests++;
        if ({stall_req_o, div_busy_o, wreg_o, wd_o, wdata_o, mem_data_o, aluop_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got stall=%b busy=%b wdata=%h exp all 0", stall_req_o, div_busy_o, wdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_directed();
        logic [2:0]  s [4] = '{SEL_ARITH, SEL_SHIFT, SEL_MULDIV, SEL_MULDIV};
        logic [6:0]  o [4] = '{OP_ADD, OP_SRA, OP_MULH, OP_MULHU};
        logic [31:0] a [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] b [4] = '{32'h1, 32'h4, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] e [4] = '{32'h80000000, 32'hF8000000, 32'h40000000, 32'hFFFFFFFE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(s[i], o[i], a[i], b[i]);
            wreg_i = 1'b1;
            #1;
            tests++;
            if (wdata_o !== e[i]) begin fails++; $display("FAIL alu_directed op=%h got %h exp %h", o[i], wdata_o, e[i]); end
            tests++;
            if (stall_req_o !== 1'b0 || wreg_o !== 1'b1) begin
                fails++; $display("FAIL alu_directed_nostall op=%h got stall=%b wreg=%b exp 0/1", o[i], stall_req_o, wreg_o);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] corners [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [2:0]  s;
        logic [6:0]  op;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 80; i++) begin
            s = 3'($urandom_range(0, 7));
            case (s)
                SEL_LOGIC:  op = 7'($urandom_range(1, 3));
                SEL_SHIFT:  op = 7'($urandom_range(4, 6));
                SEL_ARITH:  op = 7'($urandom_range(7, 10));
                SEL_MULDIV: op = 7'($urandom_range(11, 14));
                default:    op = 7'($urandom_range(0, 14));
            endcase
            if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 14));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
            exp = model(s, op, a, b);
            @(negedge clk);
            drive(s, op, a, b);
            wreg_i = 1'($urandom_range(0, 1));
            wd_i = 5'($urandom_range(0, 31));
            reg_last_i = $urandom();
            #1;
            tests++;
            if (wdata_o !== exp) begin fails++; $display("FAIL alu_random sel=%0d op=%h a=%h b=%h got %h exp %h", s, op, a, b, wdata_o, exp); end
            tests++;
            if (stall_req_o !== 1'b0 || wreg_o !== wreg_i || wd_o !== wd_i ||
                mem_data_o !== reg_last_i || aluop_o !== op) begin
                fails++; $display("FAIL alu_passthru got stall=%b wreg=%b wd=%h mem=%h aluop=%h", stall_req_o, wreg_o, wd_o, mem_data_o, aluop_o);
            end
        end
    endtask

    task automatic test_div_directed();
        run_div(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b1);
        run_div(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b1);
        run_div(OP_REMU, 32'd7, 32'd2, 32'd1, 1'b1);
    endtask

    task automatic test_div_special();
        logic [6:0]  o [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(SEL_MULDIV, o[i], a[i], b[i]);
            wreg_i = 1'b1;
            #1;
            tests++;
            if (wdata_o !== e[i] || stall_req_o !== 1'b0 || wreg_o !== 1'b1) begin
                fails++; $display("FAIL div_special op=%h got %h stall=%b exp %h stall=0", o[i], wdata_o, stall_req_o, e[i]);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (div_busy_o !== 1'b0) begin fails++; $display("FAIL div_special_idle got busy=%b exp 0", div_busy_o); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(SEL_MULDIV, OP_DIV, 32'd1000, 32'd3);
        wreg_i = 1'b1;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        tests++;
        if (stall_req_o !== 1'b1 || div_busy_o !== 1'b1) begin
            fails++; $display("FAIL flush_busy_before got stall=%b busy=%b exp 1/1", stall_req_o, div_busy_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        drive(SEL_NOP, 7'h00, 32'h0, 32'h0);
        #1;
        tests++;
        if (stall_req_o !== 1'b0 || div_busy_o !== 1'b0) begin
            fails++; $display("FAIL flush_abort got stall=%b busy=%b exp 0/0", stall_req_o, div_busy_o);
        end
        run_div(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b1);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(SEL_MULDIV, OP_DIV, 32'd77, 32'd5);
        wreg_i = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(SEL_NOP, 7'h00, 32'h0, 32'h0);
        wreg_i = 1'b0;
        #1;
        tests++;
        if (stall_req_o !== 1'b0 || div_busy_o !== 1'b0) begin
            fails++; $display("FAIL async_reset got stall=%b busy=%b exp 0/0", stall_req_o, div_busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(OP_DIV, 32'd9, 32'd3, 32'd3, 1'b1);
    endtask

    task automatic test_div_random();
        logic [6:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 7'($urandom_range(15, 18));
            a = $urandom();
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
            if ($urandom_range(0, 1) == 0) b = -b;
            if (b == 0) b = 32'd3;
            run_div(op, a, b, model(SEL_MULDIV, op, a, b), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_div(OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);
        run_div(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        run_div(OP_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 1'b1);
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div_directed();
        test_div_special();
        test_flush();
        test_async_reset();
        test_div_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
